// File: rtl/uno_turn_scheduler.sv
// UNO game sequencer: deals, flips, grants turns, applies action cards and detects the winner.
// Optional idle-turn timeout is built when TURN_TIMEOUT_EN is defined.
module uno_turn_scheduler #(
  parameter int N_PLAYERS      = 4,
  parameter int INIT_HAND      = 7,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_game_start,
  output logic [N_PLAYERS-1:0]           o_start,
  output logic                           o_draw_two,
  output logic                           o_draw_four,
  output logic [5:0]                     o_prev_card,
  input  logic [N_PLAYERS-1:0]           i_play,
  input  logic [6*N_PLAYERS-1:0]         i_play_card,
  input  logic [N_PLAYERS-1:0]           i_draw_req,
  output logic                           o_check,
  output logic                           o_reject,
  output logic                           o_deck_req,
  input  logic                           i_deck_ack,
  input  logic [5:0]                     i_deck_card,
  output logic [N_PLAYERS-1:0]           o_drawn,
  output logic [5:0]                     o_drawn_card,
  output logic [$clog2(N_PLAYERS)-1:0]   o_cur_player,
  output logic                           o_dir,
  output logic [$clog2(N_PLAYERS)-1:0]   o_winner,
  output logic                           o_game_over
);

  localparam int CW = $clog2(N_PLAYERS);
  localparam int LP = N_PLAYERS - 1;
  localparam logic [CW-1:0] LAST_P   = LP[CW-1:0];
  localparam logic [CW+1:0] NPW      = N_PLAYERS[CW+1:0];
  localparam logic [6:0]    LAST_RND = INIT_HAND[6:0] - 7'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_DEAL, S_FLIP, S_TURN, S_PENALTY, S_DRAW, S_ADVANCE, S_WIN
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE, ACT_SKIP, ACT_REV, ACT_D2, ACT_D4
  } act_t;

  state_t                state_q, state_d;
  act_t                  act_q, act_d;
  logic [CW-1:0]         cur_q, cur_d;
  logic                  dir_q, dir_d;
  logic [5:0]            prev_q, prev_d;
  logic                  req_q, req_d;
  logic [N_PLAYERS-1:0]  drawn_q, drawn_d;
  logic [5:0]            drawn_card_q, drawn_card_d;
  logic                  reject_q, reject_d;
  logic [CW-1:0]         winner_q, winner_d;
  logic [2:0]            pen_q, pen_d;
  logic                  pen_four_q, pen_four_d;
  logic [CW-1:0]         deal_tgt_q, deal_tgt_d;
  logic [6:0]            deal_rnd_q, deal_rnd_d;
  logic [6:0]            cnt_q [N_PLAYERS];
  logic [6:0]            cnt_d [N_PLAYERS];

  logic                  ack;
  logic                  deck_state;
  logic [5:0]            play_card;
  logic                  legal;
  logic                  dlv_en;
  logic [CW-1:0]         dlv_tgt;
  logic [CW+1:0]         step;
  logic [CW+1:0]         nxt;

  function automatic act_t act_of(input logic [3:0] sym);
    case (sym)
      4'd10:   act_of = ACT_SKIP;
      4'd11:   act_of = ACT_REV;
      4'd12:   act_of = ACT_D2;
      4'd14:   act_of = ACT_D4;
      default: act_of = ACT_NONE;
    endcase
  endfunction

  // Deck handshake: o_deck_req is registered, rises the cycle after a deck-using
  // state is entered and holds until i_deck_ack; the acked card is delivered
  // (o_drawn/o_drawn_card) on the next cycle, so at most one card per two cycles.
  assign ack        = req_q & i_deck_ack;
  assign deck_state = (state_q == S_DEAL) || (state_q == S_FLIP) ||
                      (state_q == S_DRAW) || (state_q == S_PENALTY);
  assign play_card  = i_play_card[6*cur_q +: 6];
  assign legal      = (play_card[5:4] == prev_q[5:4]) || (play_card[3:0] == prev_q[3:0]) ||
                      (play_card[3:0] == 4'd13) || (play_card[3:0] == 4'd14);

`ifdef TURN_TIMEOUT_EN
  localparam int TO_M1 = TIMEOUT_CYCLES - 1;
  localparam logic [19:0] TO_LIM = TO_M1[19:0];
  logic [19:0] to_cnt_q, to_cnt_d;

  // Runs only while a grant is live; any exit from S_TURN restarts it.
  assign to_cnt_d = (state_q == S_TURN) ? to_cnt_q + 20'd1 : 20'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    cur_d        = cur_q;
    dir_d        = dir_q;
    prev_d       = prev_q;
    req_d        = req_q;
    drawn_d      = '0;
    drawn_card_d = drawn_card_q;
    reject_d     = 1'b0;
    winner_d     = winner_q;
    pen_d        = pen_q;
    pen_four_d   = pen_four_q;
    deal_tgt_d   = deal_tgt_q;
    deal_rnd_d   = deal_rnd_q;
    cnt_d        = cnt_q;
    dlv_en       = 1'b0;
    dlv_tgt      = cur_q;
    step         = '0;
    nxt          = '0;

    if (req_q) begin
      if (i_deck_ack) req_d = 1'b0;
    end else if (deck_state) begin
      req_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_WIN: begin
        if (i_game_start) begin
          for (int i = 0; i < N_PLAYERS; i++) cnt_d[i] = '0;
          cur_d      = '0;
          dir_d      = 1'b0;
          pen_d      = '0;
          pen_four_d = 1'b0;
          act_d      = ACT_NONE;
          deal_tgt_d = '0;
          deal_rnd_d = '0;
          winner_d   = '0;
          state_d    = S_DEAL;
        end
      end
      S_DEAL: begin
        if (ack) begin
          dlv_en  = 1'b1;
          dlv_tgt = deal_tgt_q;
          if (deal_tgt_q == LAST_P) begin
            deal_tgt_d = '0;
            deal_rnd_d = deal_rnd_q + 7'd1;
            if (deal_rnd_q == LAST_RND) state_d = S_FLIP;
          end else begin
            deal_tgt_d = deal_tgt_q + 1'b1;
          end
        end
      end
      S_FLIP: begin
        // Wild starters go back; the request re-arms automatically.
        if (ack && (i_deck_card[3:0] != 4'd13) && (i_deck_card[3:0] != 4'd14)) begin
          prev_d  = i_deck_card;
          cur_d   = '0;
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        if (i_play[cur_q]) begin
          if (legal) begin
            prev_d        = play_card;
            cnt_d[cur_q]  = cnt_q[cur_q] - 7'd1;
            if (cnt_q[cur_q] == 7'd1) begin
              winner_d = cur_q;
              state_d  = S_WIN;
            end else begin
              act_d   = act_of(play_card[3:0]);
              state_d = S_ADVANCE;
            end
          end else begin
            reject_d = 1'b1;
          end
        end else if (i_draw_req[cur_q]) begin
          state_d = S_DRAW;
        end
`ifdef TURN_TIMEOUT_EN
        else if (to_cnt_q == TO_LIM) begin
          state_d = S_DRAW;
        end
`endif
      end
      S_DRAW: begin
        if (ack) begin
          dlv_en  = 1'b1;
          act_d   = ACT_NONE;
          state_d = S_ADVANCE;
        end
      end
      S_PENALTY: begin
        if (ack) begin
          dlv_en = 1'b1;
          pen_d  = pen_q - 3'd1;
          if (pen_q == 3'd1) begin
            act_d   = ACT_NONE;
            state_d = S_ADVANCE;
          end
        end
      end
      S_ADVANCE: begin
        step = 1;
        case (act_q)
          ACT_SKIP: step = 2;
          ACT_REV: begin
            // With two players a reverse hands the turn straight back, i.e. a skip.
            if (N_PLAYERS == 2) step = 2;
            else                dir_d = ~dir_q;
          end
          ACT_D2: begin
            pen_d      = 3'd2;
            pen_four_d = 1'b0;
          end
          ACT_D4: begin
            pen_d      = 3'd4;
            pen_four_d = 1'b1;
          end
          default: ;
        endcase
        if (!dir_d) nxt = {2'b00, cur_q} + step;
        else        nxt = {2'b00, cur_q} + NPW - step;
        if (nxt >= NPW) nxt = nxt - NPW;
        cur_d   = nxt[CW-1:0];
        act_d   = ACT_NONE;
        state_d = (pen_d != 3'd0) ? S_PENALTY : S_TURN;
      end
      default: state_d = S_IDLE;
    endcase

    if (dlv_en) begin
      drawn_d[dlv_tgt] = 1'b1;
      drawn_card_d     = i_deck_card;
      if (cnt_q[dlv_tgt] != 7'd127) cnt_d[dlv_tgt] = cnt_q[dlv_tgt] + 7'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      act_q        <= ACT_NONE;
      cur_q        <= '0;
      dir_q        <= 1'b0;
      prev_q       <= '0;
      req_q        <= 1'b0;
      drawn_q      <= '0;
      drawn_card_q <= '0;
      reject_q     <= 1'b0;
      winner_q     <= '0;
      pen_q        <= '0;
      pen_four_q   <= 1'b0;
      deal_tgt_q   <= '0;
      deal_rnd_q   <= '0;
      for (int i = 0; i < N_PLAYERS; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      cur_q        <= cur_d;
      dir_q        <= dir_d;
      prev_q       <= prev_d;
      req_q        <= req_d;
      drawn_q      <= drawn_d;
      drawn_card_q <= drawn_card_d;
      reject_q     <= reject_d;
      winner_q     <= winner_d;
      pen_q        <= pen_d;
      pen_four_q   <= pen_four_d;
      deal_tgt_q   <= deal_tgt_d;
      deal_rnd_q   <= deal_rnd_d;
      for (int i = 0; i < N_PLAYERS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    o_start = '0;
    if ((state_q == S_TURN) || (state_q == S_DRAW) || (state_q == S_PENALTY))
      o_start[cur_q] = 1'b1;
  end

  assign o_draw_two   = (state_q == S_PENALTY) && !pen_four_q;
  assign o_draw_four  = (state_q == S_PENALTY) &&  pen_four_q;
  assign o_prev_card  = prev_q;
  assign o_check      = (state_q == S_TURN) && !req_q;
  assign o_reject     = reject_q;
  assign o_deck_req   = req_q;
  assign o_drawn      = drawn_q;
  assign o_drawn_card = drawn_card_q;
  assign o_cur_player = cur_q;
  assign o_dir        = dir_q;
  assign o_winner     = winner_q;
  assign o_game_over  = (state_q == S_WIN);

endmodule

// File: tb/tb_uno_turn_scheduler.sv
// Bench for uno_turn_scheduler: deck model, delivery scoreboard and a small game model.
module tb_uno_turn_scheduler;
  localparam int NP = 4;
  localparam int IH = 7;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_game_start;
  logic [NP-1:0]   o_start;
  logic            o_draw_two, o_draw_four;
  logic [5:0]      o_prev_card;
  logic [NP-1:0]   i_play;
  logic [6*NP-1:0] i_play_card;
  logic [NP-1:0]   i_draw_req;
  logic            o_check, o_reject, o_deck_req;
  logic            i_deck_ack;
  logic [5:0]      i_deck_card;
  logic [NP-1:0]   o_drawn;
  logic [5:0]      o_drawn_card;
  logic [1:0]      o_cur_player, o_winner;
  logic            o_dir, o_game_over;

  uno_turn_scheduler #(.N_PLAYERS(NP), .INIT_HAND(IH), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_game_start(i_game_start),
    .o_start(o_start), .o_draw_two(o_draw_two), .o_draw_four(o_draw_four),
    .o_prev_card(o_prev_card), .i_play(i_play), .i_play_card(i_play_card),
    .i_draw_req(i_draw_req), .o_check(o_check), .o_reject(o_reject),
    .o_deck_req(o_deck_req), .i_deck_ack(i_deck_ack), .i_deck_card(i_deck_card),
    .o_drawn(o_drawn), .o_drawn_card(o_drawn_card), .o_cur_player(o_cur_player),
    .o_dir(o_dir), .o_winner(o_winner), .o_game_over(o_game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];   // {player, card} expected on o_drawn/o_drawn_card
  logic [5:0] deck_q[$];  // cards the deck model hands out in order
  int         obs_cnt [NP];
  logic [7:0] mon_e;

  int         m_cur, m_dir, m_win, m_pen_p, m_pen_n;
  int         m_cnt [NP];
  logic [5:0] m_prev;
  bit         m_over;

  always @(negedge clk) begin
    if (o_deck_req) begin
      i_deck_ack  = 1'b1;
      i_deck_card = (deck_q.size() != 0) ? deck_q.pop_front() : 6'h00;
    end else begin
      i_deck_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (o_drawn !== '0) begin
      if (exp_q.size() == 0) begin
        check("drawn_unexpected", 32'(o_drawn), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("drawn_tgt", 32'(o_drawn), 32'h1 << mon_e[7:6]);
        check("drawn_card", 32'(o_drawn_card), 32'(mon_e[5:0]));
      end
      for (int i = 0; i < NP; i++) if (o_drawn[i]) obs_cnt[i]++;
    end
  end

  function automatic logic [5:0] rnd_card();
    logic [1:0] col;
    logic [3:0] sym;
    col = 2'($urandom_range(0, 3));
    sym = 4'($urandom_range(0, 12));
    return {col, sym};
  endfunction

  function automatic bit legal(input logic [5:0] c, input logic [5:0] prev);
    return (c[5:4] == prev[5:4]) || (c[3:0] == prev[3:0]) || (c[3:0] == 4'd13) || (c[3:0] == 4'd14);
  endfunction

  function automatic int step_to(input int cur, input int dir, input int stp);
    return dir ? (cur + NP - stp) % NP : (cur + stp) % NP;
  endfunction

  task automatic expect_draw(input int p, input logic [5:0] c);
    logic [1:0] pp;
    pp = p[1:0];
    deck_q.push_back(c);
    exp_q.push_back({pp, c});
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (o_start != '0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      check({tag, "_grant_drop_timeout"}, 32'(o_start), 32'h0);
      return;
    end
    while (o_start == '0 && n < 400) begin @(negedge clk); n++; end
    if (o_start == '0) check({tag, "_grant_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic check_turn(input string tag);
    check({tag, "_start"}, 32'(o_start), 32'h1 << m_cur);
    check({tag, "_cur"}, 32'(o_cur_player), 32'(m_cur));
    check({tag, "_dir"}, 32'(o_dir), 32'(m_dir));
    check({tag, "_prev"}, 32'(o_prev_card), 32'(m_prev));
    check({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic drive_play(input int p, input logic [5:0] c, input bit drw);
    @(negedge clk);
    i_play[p] = 1'b1;
    i_play_card[p*6 +: 6] = c;
    if (drw) i_draw_req[p] = 1'b1;
    @(negedge clk);
    i_play = '0;
    i_draw_req = '0;
  endtask

  task automatic start_game(input logic [5:0] f1, input logic [5:0] f2);
    for (int r = 0; r < IH; r++)
      for (int p = 0; p < NP; p++) expect_draw(p, rnd_card());
    deck_q.push_back(f1);
    deck_q.push_back(f2);
    m_cur = 0; m_dir = 0; m_prev = f2; m_over = 0;
    for (int p = 0; p < NP; p++) begin m_cnt[p] = IH; obs_cnt[p] = 0; end
    @(negedge clk); i_game_start = 1'b1;
    @(negedge clk); i_game_start = 1'b0;
    wait_grant("deal");
    check_turn("deal");
    check("deal_check", 32'(o_check), 32'h1);
    check("deal_deck_left", 32'(deck_q.size()), 32'h0);
    check("deal_over", 32'(o_game_over), 32'h0);
    for (int p = 0; p < NP; p++) check("deal_count", 32'(obs_cnt[p]), 32'(IH));
  endtask

  task automatic do_turn(input string tag, input int p, input logic [5:0] c, input bit drw);
    int stp;
    if (!legal(c, m_prev)) begin
      drive_play(p, c, drw);
      check({tag, "_reject"}, 32'(o_reject), 32'h1);
      check({tag, "_rej_start"}, 32'(o_start), 32'h1 << m_cur);
      @(negedge clk);
      check({tag, "_reject_end"}, 32'(o_reject), 32'h0);
      check({tag, "_rej_cur"}, 32'(o_cur_player), 32'(m_cur));
      return;
    end
    m_prev = c;
    m_cnt[p]--;
    m_pen_n = 0;
    if (m_cnt[p] == 0) begin
      m_over = 1;
      m_win  = p;
    end else begin
      stp = 1;
      case (c[3:0])
        4'd10: stp = 2;
        4'd11: m_dir = m_dir ^ 1;
        4'd12: m_pen_n = 2;
        4'd14: m_pen_n = 4;
        default: ;
      endcase
      m_cur = step_to(m_cur, m_dir, stp);
      if (m_pen_n != 0) begin
        m_pen_p = m_cur;
        for (int k = 0; k < m_pen_n; k++) expect_draw(m_cur, rnd_card());
        m_cnt[m_cur] += m_pen_n;
        m_cur = step_to(m_cur, m_dir, 1);
      end
    end
    drive_play(p, c, drw);
    check({tag, "_no_reject"}, 32'(o_reject), 32'h0);
    if (m_over) begin
      check({tag, "_game_over"}, 32'(o_game_over), 32'h1);
      check({tag, "_winner"}, 32'(o_winner), 32'(m_win));
      check({tag, "_win_start"}, 32'(o_start), 32'h0);
      return;
    end
    if (m_pen_n != 0) begin
      wait_grant({tag, "_pen"});
      check({tag, "_pen_start"}, 32'(o_start), 32'h1 << m_pen_p);
      check({tag, "_draw_two"}, 32'(o_draw_two), 32'(m_pen_n == 2));
      check({tag, "_draw_four"}, 32'(o_draw_four), 32'(m_pen_n == 4));
    end
    wait_grant(tag);
    check_turn(tag);
  endtask

  task automatic do_draw(input string tag, input int p);
    expect_draw(p, rnd_card());
    m_cnt[p]++;
    m_cur = step_to(m_cur, m_dir, 1);
    @(negedge clk); i_draw_req[p] = 1'b1;
    @(negedge clk); i_draw_req = '0;
    wait_grant(tag);
    check_turn(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [5:0] wc;
    i_game_start = 1'b0; i_play = '0; i_play_card = '0; i_draw_req = '0;
    i_deck_ack = 1'b0; i_deck_card = '0;
    for (int p = 0; p < NP; p++) obs_cnt[p] = 0;
    repeat (3) @(negedge clk);
    check("rst_start", 32'(o_start), 32'h0);
    check("rst_deck_req", 32'(o_deck_req), 32'h0);
    check("rst_game_over", 32'(o_game_over), 32'h0);
    check("rst_cur", 32'(o_cur_player), 32'h0);
    check("rst_dir", 32'(o_dir), 32'h0);
    check("rst_prev", 32'(o_prev_card), 32'h0);
    check("rst_check", 32'(o_check), 32'h0);
    check("rst_drawn", 32'(o_drawn), 32'h0);
    check("rst_pen", 32'({o_draw_two, o_draw_four, o_reject}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    start_game(6'h0D, 6'h05);
    do_turn("match_sym", 0, 6'h15, 1'b0);
    do_turn("illegal", 1, 6'h23, 1'b0);

    // Input from a player without the grant must change nothing.
    drive_play(3, 6'h15, 1'b1);
    check("foreign_reject", 32'(o_reject), 32'h0);
    repeat (2) @(negedge clk);
    check_turn("foreign");
    check("foreign_deck_req", 32'(o_deck_req), 32'h0);

    do_turn("reverse", 1, 6'h1B, 1'b0);
    do_turn("skip", 0, 6'h1A, 1'b0);
    do_turn("skip_blue", 2, 6'h3A, 1'b0);
    do_draw("draw_req", 0);
    do_turn("draw_two_play_wins", 3, 6'h3C, 1'b1);
    do_turn("wild_d4", 1, 6'h1E, 1'b0);

    @(negedge clk); i_game_start = 1'b1;
    @(negedge clk); i_game_start = 1'b0;
    repeat (2) @(negedge clk);
    check_turn("start_ignored");
    check("start_ignored_req", 32'(o_deck_req), 32'h0);

    for (int k = 0; k < 100 && !m_over; k++) begin
      wc = {2'($urandom_range(0, 3)), 4'd13};
      do_turn("wild_loop", m_cur, wc, 1'b0);
    end
    check("win_reached", 32'(m_over), 32'h1);
    @(negedge clk);
    check("win_hold", 32'(o_game_over), 32'h1);

    start_game(6'h0E, 6'h27);
`ifdef TURN_TIMEOUT_EN
    expect_draw(0, rnd_card());
    m_cnt[0]++;
    m_cur = 1;
    wait_grant("timeout");
    check_turn("timeout");
`else
    repeat (30) @(negedge clk);
    check_turn("no_timeout");
    check("no_timeout_req", 32'(o_deck_req), 32'h0);
`endif

    // Reset in the middle of a deck request.
    deck_q.push_back(6'h01);
    @(negedge clk); i_draw_req[m_cur] = 1'b1;
    @(negedge clk); i_draw_req = '0;
    n = 0;
    while (!o_deck_req && n < 20) begin @(negedge clk); n++; end
    check("midreq_seen", 32'(o_deck_req), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midreq_drop", 32'(o_deck_req), 32'h0);
    check("midreq_start", 32'(o_start), 32'h0);
    deck_q.delete();
    repeat (2) @(negedge clk);
    check("midreq_no_drawn", 32'(o_drawn), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
